freelist: RTL and testbench

FREELIST -- requirements
Module: freelist

---
 rtl/freelist.sv | 166 ++++++++++++++++
 tb/tb_freelist.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/freelist.sv
// ---------------------------------------------------------------------------
// freelist
//   Physical-register free list for a 4-wide rename stage. Free state is a
//   SIZE-bit bitmap (bit set = register free, register 0 never free). Each
//   cycle the four lowest-numbered free registers are offered on o_preg4x.
//   Up to four tags are returned per cycle at commit. A single checkpoint
//   allows the bitmap to be rolled back on a branch mispredict.
//
//   Ports
//     i_clk        : clock, rising edge
//     i_rst_n      : asynchronous active-low reset
//     i_alloc_req  : per-slot allocation request mask
//     o_preg4x     : slot j = j-th lowest free register (slot 0 in LSBs)
//     o_alloc_ok   : allocation accepted this cycle (>= 4 free, no return)
//     i_free4x     : four tags returned at commit
//     i_free_mask  : per-slot valid for i_free4x
//     i_save_en    : take checkpoint
//     i_save_mask  : slots whose allocation precedes the branch
//     i_return     : restore checkpoint (mispredict)
//     o_busy       : checkpoint valid
//     o_count      : number of free registers
//     o_err        : sticky error flag
//
//   Optional feature: define FREELIST_CHECK_EN to enable the o_err checks
//   (free of tag 0, free of an already-free tag, request while not ok).
//   Without it o_err is tied 0.
// ---------------------------------------------------------------------------
module freelist #(
  parameter int WIDTH = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [3:0]           i_alloc_req,
  output logic [4*WIDTH-1:0]   o_preg4x,
  output logic                 o_alloc_ok,
  input  logic [4*WIDTH-1:0]   i_free4x,
  input  logic [3:0]           i_free_mask,
  input  logic                 i_save_en,
  input  logic [3:0]           i_save_mask,
  input  logic                 i_return,
  output logic                 o_busy,
  output logic [WIDTH:0]       o_count,
  output logic                 o_err
);

  localparam int SIZE = 1 << WIDTH;
  localparam logic [SIZE-1:0] RESET_MAP = {{(SIZE-1){1'b1}}, 1'b0};

  logic [SIZE-1:0]  free_q, free_d;
  logic [SIZE-1:0]  ckpt_q, ckpt_d;
  logic [SIZE-1:0]  freed_q, freed_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] preg_slot [4];
  logic [WIDTH-1:0] free_tag  [4];
  logic [WIDTH:0]   count;
  logic             alloc_ok;
  logic [SIZE-1:0]  alloc_vec;
  logic [SIZE-1:0]  save_alloc_vec;
  logic [SIZE-1:0]  free_vec;

  // Priority search for the four lowest free registers plus a popcount of
  // the registered bitmap. Slots stay 0 when fewer than four are free; in
  // that case o_alloc_ok is low so the values are never consumed.
  always_comb begin
    logic [2:0] found;
    found = 3'd0;
    count = '0;
    for (int j = 0; j < 4; j++) preg_slot[j] = '0;
    for (int i = 0; i < SIZE; i++) begin
      count = count + {{WIDTH{1'b0}}, free_q[i]};
      if (free_q[i] && (found < 3'd4)) begin
        preg_slot[found[1:0]] = WIDTH'(i);
        found = found + 3'd1;
      end
    end
  end

  assign alloc_ok = (count >= (WIDTH+1)'(4)) && !i_return;

  // Decode the allocation and free vectors for this cycle. Tag 0 and tags
  // that are already free are dropped from the free vector.
  always_comb begin
    alloc_vec      = '0;
    save_alloc_vec = '0;
    free_vec       = '0;
    for (int j = 0; j < 4; j++) begin
      free_tag[j] = i_free4x[j*WIDTH +: WIDTH];
      if (alloc_ok && i_alloc_req[j]) begin
        alloc_vec[preg_slot[j]] = 1'b1;
        if (i_save_mask[j]) save_alloc_vec[preg_slot[j]] = 1'b1;
      end
      if (i_free_mask[j] && (free_tag[j] != '0) && !free_q[free_tag[j]])
        free_vec[free_tag[j]] = 1'b1;
    end
  end

  // Next-state for the bitmap and checkpoint. Return beats save. The
  // freed-since bitmap restarts on save with this cycle's frees so that a
  // tag committed in the save cycle is not lost by a later restore.
  always_comb begin
    free_d  = free_q;
    ckpt_d  = ckpt_q;
    freed_d = freed_q;
    busy_d  = busy_q;
    if (i_return) begin
      if (busy_q) free_d = ckpt_q | freed_q | free_vec;
      else        free_d = free_q | free_vec;
      freed_d = '0;
      busy_d  = 1'b0;
    end else begin
      free_d = (free_q & ~alloc_vec) | free_vec;
      if (i_save_en) begin
        ckpt_d  = free_q & ~save_alloc_vec;
        freed_d = free_vec;
        busy_d  = 1'b1;
      end else if (busy_q) begin
        freed_d = freed_q | free_vec;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      free_q  <= RESET_MAP;
      ckpt_q  <= '0;
      freed_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      free_q  <= free_d;
      ckpt_q  <= ckpt_d;
      freed_q <= freed_d;
      busy_q  <= busy_d;
    end
  end

`ifdef FREELIST_CHECK_EN
  logic err_q, err_d;

  // Sticky misuse detector; only reset clears it.
  always_comb begin
    err_d = err_q;
    if ((|i_alloc_req) && !alloc_ok) err_d = 1'b1;
    for (int j = 0; j < 4; j++) begin
      if (i_free_mask[j] && ((free_tag[j] == '0) || free_q[free_tag[j]]))
        err_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

  assign o_preg4x   = {preg_slot[3], preg_slot[2], preg_slot[1], preg_slot[0]};
  assign o_alloc_ok = alloc_ok;
  assign o_busy     = busy_q;
  assign o_count    = count;

endmodule

// File: tb/tb_freelist.sv
// ---------------------------------------------------------------------------
// tb_freelist
//   Directed bench for freelist (WIDTH = 5). A table of vectors holds the
//   inputs for one cycle plus the outputs expected while those inputs are
//   applied (before the capturing edge). Hand-written sequences cover the
//   checkpoint/restore, exhaustion, error flag and asynchronous reset cases.
// ---------------------------------------------------------------------------
module tb_freelist;

  localparam int WIDTH = 5;

  logic                 i_clk;
  logic                 i_rst_n;
  logic [3:0]           i_alloc_req;
  logic [4*WIDTH-1:0]   o_preg4x;
  logic                 o_alloc_ok;
  logic [4*WIDTH-1:0]   i_free4x;
  logic [3:0]           i_free_mask;
  logic                 i_save_en;
  logic [3:0]           i_save_mask;
  logic                 i_return;
  logic                 o_busy;
  logic [WIDTH:0]       o_count;
  logic                 o_err;

  int total;
  int bad;

  typedef struct {
    logic [3:0]  alloc_req;
    logic [19:0] free4x;
    logic [3:0]  free_mask;
    logic        save_en;
    logic [3:0]  save_mask;
    logic        ret;
    logic [5:0]  exp_count;
    logic [19:0] exp_preg;
    logic        exp_ok;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[13];

  freelist #(.WIDTH(WIDTH)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_alloc_req (i_alloc_req),
    .o_preg4x    (o_preg4x),
    .o_alloc_ok  (o_alloc_ok),
    .i_free4x    (i_free4x),
    .i_free_mask (i_free_mask),
    .i_save_en   (i_save_en),
    .i_save_mask (i_save_mask),
    .i_return    (i_return),
    .o_busy      (o_busy),
    .o_count     (o_count),
    .o_err       (o_err)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  function automatic logic [19:0] p4(input int a3, input int a2, input int a1, input int a0);
    logic [4:0] b3, b2, b1, b0;
    b3 = a3[4:0]; b2 = a2[4:0]; b1 = a1[4:0]; b0 = a0[4:0];
    return {b3, b2, b1, b0};
  endfunction

  function automatic vec_t mkv(input logic [3:0] ar, input logic [19:0] f4, input logic [3:0] fm,
                               input logic se, input logic [3:0] sm, input logic rt,
                               input int ec, input logic [19:0] ep, input logic eo, input logic eb);
    vec_t v;
    v.alloc_req = ar; v.free4x = f4; v.free_mask = fm;
    v.save_en = se; v.save_mask = sm; v.ret = rt;
    v.exp_count = ec[5:0]; v.exp_preg = ep; v.exp_ok = eo; v.exp_busy = eb;
    return v;
  endfunction

  // Drive one cycle's inputs (called just after a falling edge).
  task automatic applyStimulus(input logic [3:0] ar, input logic [19:0] f4, input logic [3:0] fm,
                               input logic se, input logic [3:0] sm, input logic rt);
    i_alloc_req = ar;
    i_free4x    = f4;
    i_free_mask = fm;
    i_save_en   = se;
    i_save_mask = sm;
    i_return    = rt;
  endtask

  task automatic checkOutput(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  // Advance to the next falling edge, drive inputs, let combinational
  // outputs settle.
  task automatic step(input logic [3:0] ar, input logic [19:0] f4, input logic [3:0] fm,
                      input logic se, input logic [3:0] sm, input logic rt);
    @(negedge i_clk);
    applyStimulus(ar, f4, fm, se, sm, rt);
    #1;
  endtask

  task automatic idle();
    step(4'b0, 20'd0, 4'b0, 1'b0, 4'b0, 1'b0);
  endtask

  task automatic doReset();
    @(negedge i_clk);
    applyStimulus(4'b0, 20'd0, 4'b0, 1'b0, 4'b0, 1'b0);
    i_rst_n = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    i_rst_n = 1'b0;
    applyStimulus(4'b0, 20'd0, 4'b0, 1'b0, 4'b0, 1'b0);

    // Each row: inputs, then outputs seen while those inputs are applied.
    vecs[0]  = mkv(4'b0000, 20'd0,                   4'b0000, 0, 4'b0000, 0, 31, p4(4,3,2,1), 1, 0);
    vecs[1]  = mkv(4'b1111, 20'd0,                   4'b0000, 0, 4'b0000, 0, 31, p4(4,3,2,1), 1, 0);
    vecs[2]  = mkv(4'b0000, p4(0,0,0,3),             4'b0001, 0, 4'b0000, 0, 27, p4(8,7,6,5), 1, 0);
    vecs[3]  = mkv(4'b0000, 20'd0,                   4'b0000, 0, 4'b0000, 0, 28, p4(7,6,5,3), 1, 0);
    vecs[4]  = mkv(4'b0101, 20'd0,                   4'b0000, 0, 4'b0000, 0, 28, p4(7,6,5,3), 1, 0);
    vecs[5]  = mkv(4'b0000, 20'd0,                   4'b0000, 0, 4'b0000, 1, 26, p4(9,8,7,5), 0, 0);
    vecs[6]  = mkv(4'b1000, p4(0,0,6,0),             4'b0010, 0, 4'b0000, 0, 26, p4(9,8,7,5), 1, 0);
    vecs[7]  = mkv(4'b0000, p4(0,0,31,0),            4'b0011, 0, 4'b0000, 0, 26, p4(8,7,6,5), 1, 0);
    vecs[8]  = mkv(4'b0000, 20'd0,                   4'b0000, 0, 4'b0000, 0, 26, p4(8,7,6,5), 1, 0);
    vecs[9]  = mkv(4'b0010, 20'd0,                   4'b0000, 1, 4'b0010, 0, 26, p4(8,7,6,5), 1, 0);
    vecs[10] = mkv(4'b0000, 20'd0,                   4'b0000, 0, 4'b0000, 0, 25, p4(10,8,7,5), 1, 1);
    vecs[11] = mkv(4'b0000, 20'd0,                   4'b0000, 0, 4'b0000, 1, 25, p4(10,8,7,5), 0, 1);
    vecs[12] = mkv(4'b0000, 20'd0,                   4'b0000, 0, 4'b0000, 0, 25, p4(10,8,7,5), 1, 0);

    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;

    for (int k = 0; k < 13; k++) begin
      step(vecs[k].alloc_req, vecs[k].free4x, vecs[k].free_mask,
           vecs[k].save_en, vecs[k].save_mask, vecs[k].ret);
      checkOutput("count", k, 32'(o_count),    32'(vecs[k].exp_count));
      checkOutput("preg",  k, 32'(o_preg4x),   32'(vecs[k].exp_preg));
      checkOutput("ok",    k, 32'(o_alloc_ok), 32'(vecs[k].exp_ok));
      checkOutput("busy",  k, 32'(o_busy),     32'(vecs[k].exp_busy));
    end

    // Save with pre-branch slots 0/1, allocate past the branch, free a
    // pre-branch tag, then restore.
    doReset();
    step(4'b1111, 20'd0, 4'b0, 1'b1, 4'b0011, 1'b0);
    step(4'b1111, 20'd0, 4'b0, 1'b0, 4'b0000, 1'b0);
    checkOutput("s32_busy", 0, 32'(o_busy), 32'd1);
    step(4'b0000, p4(0,0,0,2), 4'b0001, 1'b0, 4'b0000, 1'b0);
    checkOutput("s32_count", 0, 32'(o_count), 32'd23);
    step(4'b0000, 20'd0, 4'b0, 1'b0, 4'b0000, 1'b1);
    idle();
    checkOutput("s32_count", 1, 32'(o_count), 32'd30);
    checkOutput("s32_preg",  1, 32'(o_preg4x), 32'(p4(5,4,3,2)));
    checkOutput("s32_busy",  1, 32'(o_busy), 32'd0);

    // Return and save together: return wins, checkpoint not retaken.
    doReset();
    step(4'b1111, 20'd0, 4'b0, 1'b1, 4'b0011, 1'b0);
    step(4'b1111, 20'd0, 4'b0, 1'b1, 4'b0011, 1'b1);
    idle();
    checkOutput("s21_busy",  0, 32'(o_busy), 32'd0);
    checkOutput("s21_count", 0, 32'(o_count), 32'd29);
    checkOutput("s21_preg",  0, 32'(o_preg4x), 32'(p4(6,5,4,3)));

    // Exhaustion: seven full allocations leave three free.
    doReset();
    repeat (7) step(4'b1111, 20'd0, 4'b0, 1'b0, 4'b0, 1'b0);
    idle();
    checkOutput("s33_count", 0, 32'(o_count), 32'd3);
    checkOutput("s33_ok",    0, 32'(o_alloc_ok), 32'd0);
    checkOutput("s33_preg",  0, 32'(o_preg4x), 32'(p4(0,31,30,29)));
    step(4'b0001, 20'd0, 4'b0, 1'b0, 4'b0, 1'b0);
    idle();
    checkOutput("s33_count", 1, 32'(o_count), 32'd3);
`ifdef FREELIST_CHECK_EN
    checkOutput("s33_err", 1, 32'(o_err), 32'd1);
`else
    checkOutput("s33_err", 1, 32'(o_err), 32'd0);
`endif

`ifdef FREELIST_CHECK_EN
    // Freeing tag 0 flags an error without changing the count.
    doReset();
    step(4'b0000, 20'd0, 4'b0001, 1'b0, 4'b0, 1'b0);
    idle();
    checkOutput("s34_err",   0, 32'(o_err), 32'd1);
    checkOutput("s34_count", 0, 32'(o_count), 32'd31);
    i_rst_n = 1'b0;
    #1;
    checkOutput("s34_err",   1, 32'(o_err), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
`endif

    // Asynchronous reset mid-operation discards the pending allocation.
    doReset();
    step(4'b1111, 20'd0, 4'b0, 1'b0, 4'b0, 1'b0);
    step(4'b1111, 20'd0, 4'b0, 1'b1, 4'b0011, 1'b0);
    i_rst_n = 1'b0;
    #1;
    checkOutput("rst_count", 0, 32'(o_count), 32'd31);
    checkOutput("rst_busy",  0, 32'(o_busy), 32'd0);
    @(negedge i_clk);
    applyStimulus(4'b0, 20'd0, 4'b0, 1'b0, 4'b0, 1'b0);
    i_rst_n = 1'b1;
    #1;
    checkOutput("rst_count", 1, 32'(o_count), 32'd31);
    checkOutput("rst_preg",  1, 32'(o_preg4x), 32'(p4(4,3,2,1)));
    checkOutput("rst_ok",    1, 32'(o_alloc_ok), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
